// File: rtl/nes_mem_pkg.sv
// Shared SRAM conventions for the CHR loader and reader: bank geometry, byte lanes
// and the reader's FSM encoding.
package nes_mem_pkg;

  localparam int unsigned CHR_BANK_BYTES = 8192;
  localparam int unsigned CHR_OFFSET_W   = $clog2(CHR_BANK_BYTES);
  localparam int unsigned SRAM_AW        = 20;
  localparam int unsigned SRAM_DW        = 16;

  // Byte address bit 0 picks the lane: even bytes in [7:0], odd bytes in [15:8].
  localparam logic LANE_HI = 1'b1;

  typedef enum logic [2:0] {
    StIdle,
    StSetup,
    StWait,
    StCapt,
    StHit
  } chr_rd_state_e;

  function automatic logic [7:0] sram_lane(input logic [SRAM_DW-1:0] word, input logic sel);
    return (sel == LANE_HI) ? word[15:8] : word[7:0];
  endfunction

endpackage

// File: rtl/chr_sram_reader.sv
// PPU-side CHR byte fetcher: banked addressing into the 16-bit SRAM, a timed read
// sequence and a one-word cache in front of it.
module chr_sram_reader
  import nes_mem_pkg::*;
#(
  parameter logic [SRAM_AW-1:0] CHR_BASE = 20'h00000,
  parameter int unsigned        RD_WAIT  = 2
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_en,
  input  logic                    i_flush,
  input  logic                    i_req,
  input  logic [7:0]              i_chr_bank,
  input  logic [CHR_OFFSET_W-1:0] i_chr_addr,
  output logic                    o_ack,
  output logic [7:0]              o_rdata,
  output logic                    o_busy,
  output logic [SRAM_AW-1:0]      o_sram_addr,
  output logic [SRAM_DW-1:0]      o_sram_wdata,
  input  logic [SRAM_DW-1:0]      i_sram_rdata,
  output logic                    o_sram_oe_n,
  output logic                    o_sram_we_n,
  output logic                    o_sram_ub_n,
  output logic                    o_sram_lb_n
);

  localparam logic [3:0] WaitLoad = 4'(RD_WAIT - 1);

  chr_rd_state_e state_q, state_d;
  logic [3:0]         wait_q, wait_d;
  logic [SRAM_AW-1:0] addr_q, addr_d;
  logic               sel_q, sel_d;
  logic [SRAM_AW-1:0] tag_q, tag_d;
  logic [SRAM_DW-1:0] data_q, data_d;
  logic               valid_q, valid_d;
  logic               ack_q, ack_d;
  logic [7:0]         rdata_q, rdata_d;
  logic               busy_q, busy_d;
  logic               bus_n_q, bus_n_d;

  logic [CHR_OFFSET_W+7:0] byte_addr;
  logic [SRAM_AW-1:0]      word_addr;
  logic                    accept;
  logic                    lookup_hit;

  assign byte_addr  = {i_chr_bank, i_chr_addr};
  assign word_addr  = CHR_BASE + byte_addr[CHR_OFFSET_W+7:1];
  // The request is still high during the ack cycle; only a request held past it counts.
  assign accept     = i_req && i_en && !ack_q;
  assign lookup_hit = valid_q && !i_flush && (tag_q == word_addr);

  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    addr_d  = addr_q;
    sel_d   = sel_q;
    tag_d   = tag_q;
    data_d  = data_q;
    valid_d = valid_q && !i_flush;
    ack_d   = 1'b0;
    rdata_d = rdata_q;
    busy_d  = busy_q;
    bus_n_d = bus_n_q;
    unique case (state_q)
      StIdle: begin
        busy_d = ack_q;
        if (accept) begin
          addr_d  = word_addr;
          sel_d   = byte_addr[0];
          busy_d  = 1'b1;
          state_d = lookup_hit ? StHit : StSetup;
        end
      end
      StHit: begin
        ack_d   = 1'b1;
        rdata_d = sram_lane(data_q, sel_q);
        state_d = StIdle;
      end
      StSetup: begin
        bus_n_d = 1'b0;
        wait_d  = WaitLoad;
        state_d = StWait;
      end
      StWait: begin
        if (wait_q == 4'd0) state_d = StCapt;
        else                wait_d  = wait_q - 4'd1;
      end
      StCapt: begin
        // Fill wins over a flush seen in the same cycle.
        tag_d   = addr_q;
        data_d  = i_sram_rdata;
        valid_d = 1'b1;
        ack_d   = 1'b1;
        rdata_d = sram_lane(i_sram_rdata, sel_q);
        bus_n_d = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= StIdle;
      wait_q  <= '0;
      addr_q  <= '0;
      sel_q   <= 1'b0;
      tag_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ack_q   <= 1'b0;
      rdata_q <= '0;
      busy_q  <= 1'b0;
      bus_n_q <= 1'b1;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      addr_q  <= addr_d;
      sel_q   <= sel_d;
      tag_q   <= tag_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ack_q   <= ack_d;
      rdata_q <= rdata_d;
      busy_q  <= busy_d;
      bus_n_q <= bus_n_d;
    end
  end

  assign o_ack        = ack_q;
  assign o_rdata      = rdata_q;
  assign o_busy       = busy_q;
  assign o_sram_addr  = addr_q;
  assign o_sram_wdata = '0;
  assign o_sram_we_n  = 1'b1;
  assign o_sram_oe_n  = bus_n_q;
  assign o_sram_ub_n  = bus_n_q;
  assign o_sram_lb_n  = bus_n_q;

endmodule
